// File: rtl/slice_size_buffer.sv
// slice_size_buffer: stores per-slice coded sizes and emits them as a table of
// fixed-width fields to a downstream bit packer with ready/enable handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// EMIT  | presenting one entry per handshake; busy=1
// DONE  | one-cycle done pulse after the last entry was accepted
module slice_size_buffer #(
  parameter int unsigned            MAX_SLICES   = 256,
  parameter int unsigned            SIZE_WIDTH   = 16,
  parameter logic [SIZE_WIDTH-1:0]  DEFAULT_SIZE = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_enable,
  input  logic [$clog2(MAX_SLICES)-1:0] wr_index,
  input  logic [SIZE_WIDTH-1:0]         wr_size,
  input  logic                          clear,
  input  logic                          start,
  input  logic [31:0]                   slice_num,
  input  logic                          flush_en,
  input  logic                          output_ready,
  output logic                          output_enable,
  output logic [63:0]                   val,
  output logic [63:0]                   size_of_bit,
  output logic                          flush_bit,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int unsigned IDX_W = $clog2(MAX_SLICES);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        remain_q, remain_d;
  logic [SIZE_WIDTH-1:0]   entry_q, entry_d;
  logic                    flush_q, flush_d;
  logic                    flush_en_q, flush_en_d;
  logic                    overflow_q, overflow_d;
  logic [MAX_SLICES-1:0]   valid_q, valid_d;

  logic [SIZE_WIDTH-1:0]   size_mem [MAX_SLICES];

  logic                    start_ok;
  logic                    over;
  logic                    advance;
  logic [IDX_W-1:0]        rd_idx;
  logic [SIZE_WIDTH-1:0]   rd_size;

  // State register; reset aborts any emission without a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (slice_num == 32'd0) ? ST_DONE : ST_EMIT;
      ST_EMIT: if (output_ready && (remain_q == '0)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; all data outputs are forced to zero outside EMIT.
  always_comb begin
    output_enable = (state_q == ST_EMIT);
    busy          = (state_q == ST_EMIT);
    done          = (state_q == ST_DONE);
    overflow      = overflow_q;
    val           = '0;
    size_of_bit   = '0;
    flush_bit     = 1'b0;
    if (state_q == ST_EMIT) begin
      val[SIZE_WIDTH-1:0] = entry_q;
      size_of_bit         = 64'(SIZE_WIDTH);
      flush_bit           = flush_q;
    end
  end

  // Entry sequencing: the presented entry is registered so later writes or
  // clears cannot disturb it; the next entry is read when it is loaded.
  always_comb begin
    start_ok   = (state_q == ST_IDLE) && start && (slice_num != 32'd0);
    over       = (slice_num > 32'(MAX_SLICES));
    advance    = (state_q == ST_EMIT) && output_ready && (remain_q != '0);
    rd_idx     = start_ok ? '0 : (idx_q + IDX_W'(1));
    rd_size    = valid_q[rd_idx] ? size_mem[rd_idx] : DEFAULT_SIZE;

    idx_d      = idx_q;
    remain_d   = remain_q;
    entry_d    = entry_q;
    flush_d    = flush_q;
    flush_en_d = flush_en_q;
    if (start_ok) begin
      idx_d      = '0;
      remain_d   = over ? IDX_W'(MAX_SLICES - 1) : IDX_W'(slice_num - 32'd1);
      entry_d    = rd_size;
      flush_en_d = flush_en;
      flush_d    = flush_en && (remain_d == '0);
    end else if (advance) begin
      idx_d    = idx_q + IDX_W'(1);
      remain_d = remain_q - IDX_W'(1);
      entry_d  = rd_size;
      flush_d  = flush_en_q && (remain_q == IDX_W'(1));
    end

    overflow_d = overflow_q | ((state_q == ST_IDLE) && start && over);
  end

  // Valid flags: clear wipes everything, a same-cycle write survives it.
  always_comb begin
    valid_d = valid_q;
    if (clear) valid_d = '0;
    if (wr_enable) valid_d[wr_index] = 1'b1;
  end

  // Datapath and flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      remain_q   <= '0;
      entry_q    <= '0;
      flush_q    <= 1'b0;
      flush_en_q <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      idx_q      <= idx_d;
      remain_q   <= remain_d;
      entry_q    <= entry_d;
      flush_q    <= flush_d;
      flush_en_q <= flush_en_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  // Size storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clock) begin
    if (wr_enable) size_mem[wr_index] <= wr_size;
  end

endmodule

// File: doc/slice_size_buffer.md
SLICE_SIZE_BUFFER -- requirements
Module: slice_size_buffer

Interface
REQ-001 SHALL have parameter MAX_SLICES, 256: depth of size storage, power of two, ≥2.
REQ-002 SHALL have parameter SIZE_WIDTH, 16: bit width of one slice size entry, 1..64.
REQ-003 SHALL have parameter DEFAULT_SIZE, 0: value emitted for an entry not written since last clear.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port wr_enable  input  1  write one slice size this cycle.
REQ-007 SHALL have port wr_index  input  log2(MAX_SLICES)  slice index to write.
REQ-008 SHALL have port wr_size  input  SIZE_WIDTH  coded size of that slice.
REQ-009 SHALL have port clear  input  1  invalidate all stored entries.
REQ-010 SHALL have port start  input  1  begin emitting a table, one-cycle pulse.
REQ-011 SHALL have port slice_num  input  32  number of entries to emit, sampled with start.
REQ-012 SHALL have port flush_en  input  1  assert flush_bit on last entry, sampled with start.
REQ-013 SHALL have port output_ready  input  1  downstream bit packer accepts current entry.
REQ-014 SHALL have port output_enable  output  1  val/size_of_bit/flush_bit valid.
REQ-015 SHALL have port val  output  64  entry value, zero-extended.
REQ-016 SHALL have port size_of_bit  output  64  field width to pack.
REQ-017 SHALL have port flush_bit  output  1  byte-align after this field.
REQ-018 SHALL have port busy  output  1  table emission in progress.
REQ-019 SHALL have port done  output  1  one-cycle pulse after last entry accepted.
REQ-020 SHALL have port overflow  output  1  sticky: slice_num exceeded MAX_SLICES.

Function
REQ-021 SHALL implement states IDLE, EMIT, DONE; IDLE→EMIT on start with slice_num>0; IDLE→DONE on start with slice_num=0; EMIT→DONE on acceptance of last entry; DONE→IDLE unconditionally next cycle.
REQ-022 SHALL assert done only in state DONE; busy SHALL equal state EMIT.
REQ-023 SHALL ignore start while not in IDLE (no restart, no latch).
REQ-024 SHALL clamp emitted count to MAX_SLICES when slice_num>MAX_SLICES and set overflow, held until reset.
REQ-025 SHALL present entry 0 with output_enable=1 in the cycle after start (latency 1).
REQ-026 SHALL hold val, size_of_bit, flush_bit stable while output_enable=1 and output_ready=0.
REQ-027 SHALL advance to entry i+1 in the cycle after output_ready=1 with output_enable=1 (one entry per cycle when output_ready held high).
REQ-028 SHALL drive val={zeros, stored size} if entry written since last clear, else {zeros, DEFAULT_SIZE}.
REQ-029 SHALL drive size_of_bit=SIZE_WIDTH while output_enable=1, 0 otherwise.
REQ-030 SHALL drive flush_bit=1 only on last entry when sampled flush_en=1.
REQ-031 SHALL drive output_enable=0, val=0, size_of_bit=0, flush_bit=0 outside EMIT.
REQ-032 SHALL let a write take effect at its clock edge; entries loaded for output in a later cycle see it, an entry already presented SHALL NOT change.
REQ-033 SHALL let wr_enable and clear in the same cycle result in the written entry valid and all others invalid.
REQ-034 SHALL apply clear in EMIT to entries not yet presented.

Reset
REQ-035 SHALL on reset assert immediately: state IDLE, all valid flags cleared, output_enable=0, val=0, size_of_bit=0, flush_bit=0, busy=0, done=0, overflow=0; reset mid-EMIT SHALL abort without done pulse.

Verification
REQ-036 SHALL cover: write sizes 0x100,0x200,0x300 to idx 0..2, start slice_num=3 flush_en=1, ready high -> 3 consecutive entries val 0x100/0x200/0x300, size_of_bit 16, flush_bit only on third, done one cycle later.
REQ-037 SHALL cover: same table, output_ready toggled 1-0-0-1 -> each entry held stable while ready low, no entry skipped or repeated.
REQ-038 SHALL cover: clear, write idx 1 only, start slice_num=3, DEFAULT_SIZE=0 -> vals 0, written value, 0.
REQ-039 SHALL cover: start slice_num=0 -> no output_enable, done pulse cycle after start; start slice_num=300 (MAX_SLICES=256) -> 256 entries, overflow=1.
REQ-040 SHALL cover: start while busy -> ignored, sequence continues; reset asserted at entry 2 -> outputs zero immediately, no done, next start runs normally.
